// File: rtl/rs_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  Module      : rs_syndrome_calc
//  Description : Streaming syndrome calculator S1..S6 for RS(N,N-6) over
//                GF(256), using Horner evaluation at alpha^1..alpha^6.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_syndrome_calc #(
    parameter int         N         = 255,
    parameter logic [7:0] PRIM_POLY = 8'h1D
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic [7:0] data_in,
    output logic       syn_valid,
    output logic       err_flag,
    output logic [7:0] S1,
    output logic [7:0] S2,
    output logic [7:0] S3,
    output logic [7:0] S4,
    output logic [7:0] S5,
    output logic [7:0] S6,
    output logic       busy
);

    localparam int             NUM_SYN  = 6;
    localparam int             CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? PRIM_POLY : 8'h00);
    endfunction

    // Fixed-bound loop so each root unrolls to exactly pw chained xtime stages.
    function automatic logic [7:0] mul_alpha_pow(input logic [7:0] x, input int pw);
        logic [7:0] r;
        r = x;
        for (int k = 0; k < NUM_SYN; k++) begin
            if (k < pw) r = xtime(r);
        end
        return r;
    endfunction

    logic [CNT_W-1:0]         sym_cnt_q, sym_cnt_d;
    logic [NUM_SYN-1:0][7:0]  acc_q, acc_d;
    logic [NUM_SYN-1:0][7:0]  syn_q, syn_d;
    logic [NUM_SYN-1:0][7:0]  horner;
    logic                     syn_valid_q, syn_valid_d;
    logic                     err_flag_q, err_flag_d;
    logic                     first_sym;
    logic                     last_sym;

    generate
        for (genvar gi = 0; gi < NUM_SYN; gi++) begin : g_horner
            assign horner[gi] = mul_alpha_pow(acc_q[gi], gi + 1) ^ data_in;
        end
    endgenerate

    // in_sop always wins, even on what would otherwise be the last symbol.
    assign first_sym = in_sop || (sym_cnt_q == '0);
    assign last_sym  = !first_sym && (sym_cnt_q == LAST_IDX);

    always_comb begin
        sym_cnt_d   = sym_cnt_q;
        acc_d       = acc_q;
        syn_d       = syn_q;
        err_flag_d  = err_flag_q;
        syn_valid_d = 1'b0;
        if (in_valid) begin
            if (first_sym) begin
                acc_d     = {NUM_SYN{data_in}};
                sym_cnt_d = CNT_W'(1);
            end else if (last_sym) begin
                acc_d       = horner;
                syn_d       = horner;
                err_flag_d  = |horner;
                syn_valid_d = 1'b1;
                sym_cnt_d   = '0;
            end else begin
                acc_d     = horner;
                sym_cnt_d = sym_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sym_cnt_q   <= '0;
            acc_q       <= '0;
            syn_q       <= '0;
            syn_valid_q <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            sym_cnt_q   <= sym_cnt_d;
            acc_q       <= acc_d;
            syn_q       <= syn_d;
            syn_valid_q <= syn_valid_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign syn_valid = syn_valid_q;
    assign err_flag  = err_flag_q;
    assign S1        = syn_q[0];
    assign S2        = syn_q[1];
    assign S3        = syn_q[2];
    assign S4        = syn_q[3];
    assign S5        = syn_q[4];
    assign S6        = syn_q[5];
    assign busy      = (sym_cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_rs_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_syndrome_calc
//  Description : Randomised bench for rs_syndrome_calc with a direct
//                polynomial-evaluation reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_syndrome_calc;

    localparam int N = 255;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_sop;
    logic [7:0] data_in;
    logic       syn_valid;
    logic       err_flag;
    logic [7:0] S1, S2, S3, S4, S5, S6;
    logic       busy;

    rs_syndrome_calc #(.N(N), .PRIM_POLY(8'h1D)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .data_in  (data_in),
        .syn_valid(syn_valid),
        .err_flag (err_flag),
        .S1       (S1),
        .S2       (S2),
        .S3       (S3),
        .S4       (S4),
        .S5       (S5),
        .S6       (S6),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = 0;
    int prev_pulse_cyc = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
        return p[7:0];
    endfunction

    logic [7:0] alog [255];
    logic [7:0] m_cw [$];
    int         m_cnt;
    logic       exp_sv;
    logic       exp_err;
    logic [7:0] exp_S [6];

    task automatic model_reset();
        m_cw.delete();
        m_cnt   = 0;
        exp_sv  = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i < 6; i++) exp_S[i] = 8'h00;
    endtask

    // S_i = sum_k r_k * alpha^(i*power_k), symbol 0 carries power N-1.
    task automatic model_complete();
        logic [7:0] s;
        exp_err = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            s = 8'h00;
            for (int k = 0; k < N; k++)
                s = s ^ gf_mul(m_cw[k], alog[(i * (N - 1 - k)) % 255]);
            exp_S[i-1] = s;
            if (s != 8'h00) exp_err = 1'b1;
        end
        exp_sv = 1'b1;
    endtask

    task automatic model_update(input logic v, input logic s, input logic [7:0] d);
        exp_sv = 1'b0;
        if (v) begin
            if (m_cnt == 0 || s) begin
                m_cw.delete();
                m_cw.push_back(d);
                m_cnt = 1;
            end else begin
                m_cw.push_back(d);
                if (m_cnt == N - 1) begin
                    model_complete();
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (started) begin
                chk("syn_valid", 32'(syn_valid), 32'(exp_sv));
                chk("busy", 32'(busy), 32'(m_cnt != 0));
                chk("err_flag", 32'(err_flag), 32'(exp_err));
                chk("S1", 32'(S1), 32'(exp_S[0]));
                chk("S2", 32'(S2), 32'(exp_S[1]));
                chk("S3", 32'(S3), 32'(exp_S[2]));
                chk("S4", 32'(S4), 32'(exp_S[3]));
                chk("S5", 32'(S5), 32'(exp_S[4]));
                chk("S6", 32'(S6), 32'(exp_S[5]));
                if (syn_valid) begin
                    pulse_cnt++;
                    prev_pulse_cyc = last_pulse_cyc;
                    last_pulse_cyc = cyc;
                end
            end
        end
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [7:0] tx [N];

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sop   = s;
        data_in  = d;
        @(posedge clock);
        model_update(v, s, d);
        @(negedge clock);
    endtask

    task automatic send_tx(input int gap_pct, input logic sop_first);
        for (int k = 0; k < N; k++) begin
            while (int'($urandom_range(99)) < gap_pct)
                step(1'b0, 1'($urandom_range(1)), 8'($urandom));
            step(1'b1, (k == 0) ? sop_first : 1'b0, tx[k]);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic clear_tx();
        for (int k = 0; k < N; k++) tx[k] = 8'h00;
    endtask

    task automatic random_tx();
        for (int k = 0; k < N; k++) tx[k] = 8'($urandom);
    endtask

    task automatic pin_all(input string name, input logic [7:0] v);
        chk({name, "_S1"}, 32'(S1), 32'(v));
        chk({name, "_S2"}, 32'(S2), 32'(v));
        chk({name, "_S3"}, 32'(S3), 32'(v));
        chk({name, "_S4"}, 32'(S4), 32'(v));
        chk({name, "_S5"}, 32'(S5), 32'(v));
        chk({name, "_S6"}, 32'(S6), 32'(v));
    endtask

    task automatic pin_single_power1(input string name);
        chk({name, "_S1"}, 32'(S1), 32'd2);
        chk({name, "_S2"}, 32'(S2), 32'd4);
        chk({name, "_S3"}, 32'(S3), 32'd8);
        chk({name, "_S4"}, 32'(S4), 32'd16);
        chk({name, "_S5"}, 32'(S5), 32'd32);
        chk({name, "_S6"}, 32'(S6), 32'd64);
    endtask

    initial begin
        int pc;
        alog[0] = 8'h01;
        for (int k = 1; k < 255; k++) alog[k] = gf_mul(alog[k-1], 8'h02);
        model_reset();

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_syn_valid", 32'(syn_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        pin_all("rst", 8'h00);
        reset_n = 1'b1;
        started = 1;
        @(negedge clock);

        // All-zero codeword
        clear_tx();
        pc = pulse_cnt;
        send_tx(0, 1'b1);
        chk("t1_pulse", 32'(pulse_cnt - pc), 32'd1);
        chk("t1_err", 32'(err_flag), 32'd0);
        pin_all("t1", 8'h00);

        // Constant term only
        clear_tx();
        tx[N-1] = 8'h01;
        send_tx(0, 1'b0);
        pin_all("t2a", 8'h01);
        chk("t2a_err", 32'(err_flag), 32'd1);
        tx[N-1] = 8'h05;
        send_tx(0, 1'b0);
        pin_all("t2b", 8'h05);

        // Single error at power 1
        clear_tx();
        tx[N-2] = 8'h01;
        send_tx(0, 1'b1);
        pin_single_power1("t3");

        // Power 8, then linearity with power 1
        clear_tx();
        tx[N-9] = 8'h01;
        send_tx(0, 1'b0);
        chk("t4a_S1", 32'(S1), 32'd29);
        chk("t4a_S2", 32'(S2), 32'd76);
        tx[N-2] = 8'h01;
        send_tx(0, 1'b0);
        chk("t4b_S1", 32'(S1), 32'd31);
        chk("t4b_S2", 32'(S2), 32'd72);

        // Back-to-back, no gaps
        random_tx();
        send_tx(0, 1'($urandom_range(1)));
        random_tx();
        send_tx(0, 1'($urandom_range(1)));
        chk("t5_spacing", 32'(last_pulse_cyc - prev_pulse_cyc), 32'(N));

        // Random gaps
        for (int r = 0; r < 4; r++) begin
            random_tx();
            send_tx(25, 1'($urandom_range(1)));
        end

        // Restart mid-codeword at symbol 100
        pc = pulse_cnt;
        for (int k = 0; k < 100; k++) step(1'b1, (k == 0), 8'($urandom));
        clear_tx();
        tx[N-2] = 8'h01;
        send_tx(0, 1'b1);
        chk("t6a_pulse", 32'(pulse_cnt - pc), 32'd1);
        pin_single_power1("t6a");

        // Restart on what would have been the last symbol
        pc = pulse_cnt;
        for (int k = 0; k < N - 1; k++) step(1'b1, 1'b0, 8'($urandom));
        random_tx();
        send_tx(10, 1'b1);
        chk("t6b_pulse", 32'(pulse_cnt - pc), 32'd1);

        // Async reset at symbol 50
        random_tx();
        send_tx(0, 1'b0);
        for (int k = 0; k < 50; k++) step(1'b1, 1'b0, 8'($urandom));
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("t6c_rst_syn_valid", 32'(syn_valid), 32'd0);
        chk("t6c_rst_busy", 32'(busy), 32'd0);
        chk("t6c_rst_err", 32'(err_flag), 32'd0);
        pin_all("t6c_rst", 8'h00);
        @(negedge clock);
        step(1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        clear_tx();
        pc = pulse_cnt;
        send_tx(0, 1'b0);
        chk("t6c_pulse", 32'(pulse_cnt - pc), 32'd1);
        chk("t6c_err", 32'(err_flag), 32'd0);
        pin_all("t6c", 8'h00);

        repeat (3) step(1'b0, 1'b0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
